load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the EX/MEM pipeline stage and data_memory, the word-only RAM with an async read and a sync write.
//  Decodes RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW from funct3 and addr[1:0].
//  Loads: selects the byte lane and sign/zero-extends. SW: writes directly.
//  SB/SH: performs a 2-cycle read-modify-write. Misaligned or illegal accesses raise a fault and never touch memory.
// PARAMETERS
//  XLEN        32  data/address width; only 32 is supported
//  WORD_ADDR_W 10  word-index bits that data_memory decodes (addr[11:2])
// PORTS
//  clk             in   1     rising-edge clock
//  reset           in   1     synchronous, active-high reset
//  req_valid       in   1     access request present this cycle
//  req_ready       out  1     1 = request accepted this cycle (state IDLE)
//  req_store       in   1     1 = store, 0 = load
//  funct3          in   3     RISC-V funct3 of the load/store
//  addr            in   32    byte address
//  store_data      in   32    rs2 value; low byte/half used for SB/SH
//  load_valid      out  1     registered pulse: load_data valid
//  load_data       out  32    extended load result
//  fault           out  1     registered pulse: access rejected
//  fault_cause     out  2     01 misaligned, 10 illegal funct3
//  mem_read        out  1     to data_memory.mem_read
//  mem_write       out  1     to data_memory.mem_write
//  mem_address     out  32    to data_memory.address, always {word,2'b00}
//  mem_write_data  out  32    to data_memory.write_data
//  mem_read_data   in   32    from data_memory.read_data
// BEHAVIOUR
//  Reset: state=IDLE; load_valid=0, fault=0, fault_cause=0, load_data=0.
//   mem_read and mem_write are forced 0 in any cycle with reset=1.
//  req_ready = (state==IDLE) && !reset. Accept = req_valid && req_ready.
//  Legality:
//   - funct3 3, 6, 7 -> illegal.
//   - H forms with addr[0]=1 -> misaligned.
//   - W forms with addr[1:0]!=0 -> misaligned.
//   - Illegal takes priority over misaligned.
//  Faulting accept: no mem_read/mem_write. Next cycle fault=1 with its cause; load_valid=0.
//  Load accept: mem_read=1 and mem_address=addr&~3 in the same cycle.
//   - Lane = mem_read_data >> (8*addr[1:0]); sign-extend for LB/LH, zero-extend for LBU/LHU.
//   - Result registered: load_data/load_valid appear the next cycle (latency 1). Back-to-back loads are allowed.
//  SW accept: mem_write=1 with mem_write_data=store_data in the same cycle. Stays in IDLE, no stall.
//  SB/SH accept (IDLE->WRITE):
//   - mem_read=1 this cycle.
//   - merged = mem_read_data with the addressed byte/half replaced by store_data[7:0]/[15:0].
//   - Register merged and the word address.
//  WRITE: req_ready=0; mem_write=1, mem_address=captured, mem_write_data=merged; -> IDLE next cycle.
//   A request arriving in WRITE is held by upstream and accepted in the following IDLE cycle,
//   so a read after a sub-word store always sees the new data.
//  load_valid and fault are single-cycle pulses and are 0 when there is no accept.
//  Reset during WRITE: the write is dropped (mem_write=0), state returns to IDLE, and the memory word is unchanged.
//  Address bits above [11:2] pass through unchanged; data_memory ignores them (wrap at 4 KiB).
// STRUCTURE
//  Package lsu_pkg holds:
//   - F3_LB..F3_SW localparams, FAULT_NONE/MISALIGNED/ILLEGAL codes
//   - state encoding IDLE/WRITE
//   - func legal(funct3, addr[1:0])
//  Sub-module lsu_byte_lane (combinational) provides extract+extend and merge.
//  The top holds the FSM, the capture registers and the output registers.
// TESTING
//  Preload word 0x10=0x8899AABB:
//   - LB 0x11 -> next cycle load_valid=1, load_data=0xFFFFFFAA.
//   - LBU 0x13 -> 0x00000088.
//   - LH 0x12 -> 0xFFFF8899.
//  SB 0x12, store_data=0x000000C3:
//   - cycle0 mem_read=1, req_ready=1.
//   - cycle1 req_ready=0, mem_write=1, mem_address=0x10, mem_write_data=0x88C3AABB.
//  SW 0x20 0xDEADBEEF -> mem_write=1 in the accept cycle, no stall; LW 0x20 next -> 0xDEADBEEF.
//  Rejected accesses, each with no mem_read/mem_write:
//   - LW 0x22 -> fault=1, cause=01.
//   - SH 0x15 -> fault=1, cause=01.
//   - funct3=3 -> cause=10.
//  SH 0x16 0x1234 then LH 0x16 on consecutive valid cycles:
//   - LH is held one cycle.
//   - Returns 0x00001234; word 0x14 upper half = 0x1234.
//  Reset asserted in WRITE -> mem_write=0 that cycle, req_ready=1 next cycle, word unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared decode constants, state encoding and legality check for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [1:0] FAULT_NONE       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGNED = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL    = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } lsu_state_e;

  // Returns the fault code for an access; illegal funct3 outranks misalignment.
  function automatic logic [1:0] legal(input logic [2:0] funct3, input logic [1:0] lo);
    logic [1:0] code;
    code = FAULT_NONE;
    if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7)
      code = FAULT_ILLEGAL;
    else if (funct3[1:0] == SIZE_H && lo[0])
      code = FAULT_MISALIGNED;
    else if (funct3[1:0] == SIZE_W && lo != 2'b00)
      code = FAULT_MISALIGNED;
    return code;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response bundle of the load/store unit.
interface load_store_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_store;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] store_data;
  logic            load_valid;
  logic [XLEN-1:0] load_data;
  logic            fault;
  logic [1:0]      fault_cause;

  modport master (
    output req_valid, req_store, funct3, addr, store_data,
    input  req_ready, load_valid, load_data, fault, fault_cause
  );

  modport slave (
    input  req_valid, req_store, funct3, addr, store_data,
    output req_ready, load_valid, load_data, fault, fault_cause
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  output logic [31:0] load_ext,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;
  logic [31:0] ins;

  assign sh      = {lo, 3'b000};
  assign shifted = rdata >> sh;

  always_comb begin
    load_ext = shifted;
    mask     = '1;
    ins      = store_data;
    case (funct3[1:0])
      SIZE_B: begin
        load_ext = funct3[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        mask     = 32'h0000_00FF << sh;
        ins      = {24'h0, store_data[7:0]} << sh;
      end
      SIZE_H: begin
        load_ext = funct3[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        mask     = 32'h0000_FFFF << sh;
        ins      = {16'h0, store_data[15:0]} << sh;
      end
      default: ;
    endcase
    merged = (rdata & ~mask) | ins;
  end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between EX/MEM and a word-only data memory; SB/SH use a
// two-cycle read-modify-write, faulting accesses never reach memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned WORD_ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  load_store_unit_if.slave     bus,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [XLEN-1:0]      mem_address,
  output logic [XLEN-1:0]      mem_write_data,
  input  logic [XLEN-1:0]      mem_read_data
);
  if (XLEN != 32 || WORD_ADDR_W + 2 > XLEN) begin : g_bad_cfg
    $error("load_store_unit supports XLEN=32 with WORD_ADDR_W <= 30 only");
  end

  lsu_state_e  state;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        load_valid_q;
  logic [31:0] load_data_q;
  logic        fault_q;
  logic [1:0]  fault_cause_q;

  logic        ready;
  logic        accept;
  logic [1:0]  cause;
  logic        ok;
  logic        is_word;
  logic [31:0] word_addr;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign ready     = (state == IDLE) && !reset;
  assign accept    = bus.req_valid && ready;
  assign cause     = legal(bus.funct3, bus.addr[1:0]);
  assign ok        = accept && (cause == FAULT_NONE);
  assign is_word   = (bus.funct3[1:0] == SIZE_W);
  assign word_addr = {bus.addr[31:2], 2'b00};

  lsu_byte_lane u_lane (
    .rdata      (mem_read_data),
    .lo         (bus.addr[1:0]),
    .funct3     (bus.funct3),
    .store_data (bus.store_data),
    .load_ext   (load_ext),
    .merged     (merged)
  );

  // SW writes straight through in IDLE; the WRITE cycle owns the bus otherwise.
  always_comb begin
    mem_read       = ok && !(bus.req_store && is_word);
    mem_write      = (state == WRITE) ? !reset : (ok && bus.req_store && is_word);
    mem_address    = (state == WRITE) ? wr_addr : word_addr;
    mem_write_data = (state == WRITE) ? wr_data : bus.store_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wr_addr       <= '0;
      wr_data       <= '0;
      load_valid_q  <= 1'b0;
      load_data_q   <= '0;
      fault_q       <= 1'b0;
      fault_cause_q <= FAULT_NONE;
    end else begin
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (cause != FAULT_NONE) begin
              fault_q       <= 1'b1;
              fault_cause_q <= cause;
            end else if (!bus.req_store) begin
              load_valid_q <= 1'b1;
              load_data_q  <= load_ext;
            end else if (!is_word) begin
              state   <= WRITE;
              wr_addr <= word_addr;
              wr_data <= merged;
            end
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = ready;
  assign bus.load_valid  = load_valid_q;
  assign bus.load_data   = load_data_q;
  assign bus.fault       = fault_q;
  assign bus.fault_cause = fault_cause_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomised plus directed bench for load_store_unit against a byte-array memory model.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if #(.XLEN(32)) bus ();

  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [31:0] dmem [1024];

  assign mem_read_data = dmem[mem_address[11:2]];
  always @(posedge clk) if (mem_write) dmem[mem_address[11:2]] <= mem_write_data;

  load_store_unit #(.XLEN(32), .WORD_ADDR_W(10)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  logic [7:0] refb [4096];
  int checks = 0;
  int errors = 0;

  bit          pend = 0;
  logic [31:0] pend_addr, pend_word;
  bit          obs_rdy, obs_rd, obs_wr, last_acc;
  logic [31:0] obs_addr, obs_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int unsigned b;
    b = {20'h0, a[11:2], 2'b00};
    return {refb[b+3], refb[b+2], refb[b+1], refb[b]};
  endfunction

  function automatic logic [1:0] ref_cause(input logic [2:0] f3, input logic [31:0] a);
    int unsigned n;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 2'b10;
    n = 1 << f3[1:0];
    if ((a % n) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned n;
    logic [31:0] v;
    n = 1 << f3[1:0];
    v = 0;
    for (int unsigned i = 0; i < n; i++) v = v | (32'(refb[a[11:0] + i]) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
    return v;
  endfunction

  task automatic set_word(input int unsigned w, input logic [31:0] val);
    dmem[w] = val;
    for (int unsigned i = 0; i < 4; i++) refb[4*w + i] = val[8*i +: 8];
  endtask

  task automatic step(input bit rst, input bit v, input bit st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d, output bit acc);
    bit e_rdy, e_rd, e_wr, n_lv, n_fault;
    logic [1:0]  cause, n_cause;
    logic [31:0] e_addr, e_wd, n_ld, w;
    int unsigned n;
    reset = rst; bus.req_valid = v; bus.req_store = st; bus.funct3 = f3;
    bus.addr = a; bus.store_data = d;
    #4;
    e_rdy = !pend && !rst;
    acc = v && e_rdy;
    cause = ref_cause(f3, a);
    e_rd = 0; e_wr = 0; e_addr = {a[31:2], 2'b00}; e_wd = d;
    n_lv = 0; n_fault = 0; n_cause = 0; n_ld = 0;
    if (rst) begin
      pend = 0;
    end else if (pend) begin
      e_wr = 1; e_addr = pend_addr; e_wd = pend_word;
      for (int unsigned i = 0; i < 4; i++) refb[{pend_addr[11:2], 2'b00} + i] = pend_word[8*i +: 8];
      pend = 0;
    end else if (acc) begin
      n = 1 << f3[1:0];
      if (cause != 0) begin
        n_fault = 1; n_cause = cause;
      end else if (!st) begin
        e_rd = 1; n_lv = 1; n_ld = ref_load(f3, a);
      end else if (n == 4) begin
        e_wr = 1;
        for (int unsigned i = 0; i < 4; i++) refb[a[11:0] + i] = d[8*i +: 8];
      end else begin
        e_rd = 1;
        w = ref_word(a);
        for (int unsigned i = 0; i < n; i++) w[8*(a[1:0] + i) +: 8] = d[8*i +: 8];
        pend = 1; pend_addr = {a[31:2], 2'b00}; pend_word = w;
      end
    end
    obs_rdy = bus.req_ready; obs_rd = mem_read; obs_wr = mem_write;
    obs_addr = mem_address; obs_wd = mem_write_data; last_acc = acc;
    check("req_ready", 32'(bus.req_ready), 32'(e_rdy));
    check("mem_read", 32'(mem_read), 32'(e_rd));
    check("mem_write", 32'(mem_write), 32'(e_wr));
    if (e_rd || e_wr) check("mem_address", mem_address, e_addr);
    if (e_wr) check("mem_write_data", mem_write_data, e_wd);
    @(posedge clk); #1;
    check("load_valid", 32'(bus.load_valid), 32'(n_lv));
    check("fault", 32'(bus.fault), 32'(n_fault));
    if (n_lv || rst) check("load_data", bus.load_data, n_ld);
    if (n_fault || rst) check("fault_cause", 32'(bus.fault_cause), 32'(n_cause));
  endtask

  task automatic idle(input int unsigned cycles);
    bit acc;
    for (int unsigned i = 0; i < cycles; i++) step(0, 0, 0, 3'd0, 32'h0, 32'h0, acc);
  endtask

  logic [2:0] st_f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

  initial begin
    bit acc, have;
    logic [31:0] old, ra, rd;
    logic [2:0]  rf;
    bit          rs;
    reset = 1; bus.req_valid = 0; bus.req_store = 0; bus.funct3 = 0;
    bus.addr = 0; bus.store_data = 0;
    for (int unsigned w = 0; w < 1024; w++) set_word(w, $urandom);
    set_word(32'h10 >> 2, 32'h8899AABB);
    @(posedge clk); #1;
    step(1, 1, 0, 3'd2, 32'h10, 32'h0, acc);
    step(1, 1, 1, 3'd2, 32'h10, 32'h0, acc);

    step(0, 1, 0, 3'd0, 32'h11, 32'h0, acc);
    check("lb_11", bus.load_data, 32'hFFFFFFAA);
    step(0, 1, 0, 3'd4, 32'h13, 32'h0, acc);
    check("lbu_13", bus.load_data, 32'h00000088);
    step(0, 1, 0, 3'd1, 32'h12, 32'h0, acc);
    check("lh_12", bus.load_data, 32'hFFFF8899);

    step(0, 1, 1, 3'd0, 32'h12, 32'h000000C3, acc);
    check("sb_c0_read", 32'(obs_rd), 32'd1);
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, acc);
    check("sb_c1_ready", 32'(obs_rdy), 32'd0);
    check("sb_c1_addr", obs_addr, 32'h10);
    check("sb_c1_wdata", obs_wd, 32'h88C3AABB);

    step(0, 1, 1, 3'd2, 32'h20, 32'hDEADBEEF, acc);
    check("sw_write", 32'(obs_wr), 32'd1);
    step(0, 1, 0, 3'd2, 32'h20, 32'h0, acc);
    check("lw_20", bus.load_data, 32'hDEADBEEF);

    step(0, 1, 0, 3'd2, 32'h22, 32'h0, acc);
    check("lw_22_cause", 32'(bus.fault_cause), 32'd1);
    step(0, 1, 1, 3'd1, 32'h15, 32'h0, acc);
    check("sh_15_cause", 32'(bus.fault_cause), 32'd1);
    step(0, 1, 0, 3'd3, 32'h20, 32'h0, acc);
    check("f3_3_cause", 32'(bus.fault_cause), 32'd2);

    step(0, 1, 1, 3'd1, 32'h16, 32'h00001234, acc);
    step(0, 1, 0, 3'd1, 32'h16, 32'h0, acc);
    check("lh_held", 32'(last_acc), 32'd0);
    step(0, 1, 0, 3'd1, 32'h16, 32'h0, acc);
    check("lh_16", bus.load_data, 32'h00001234);
    check("word14_hi", 32'(dmem[5][31:16]), 32'h1234);

    old = dmem[16];
    step(0, 1, 1, 3'd0, 32'h41, 32'h5A, acc);
    step(1, 0, 0, 3'd0, 32'h0, 32'h0, acc);
    check("rst_write_dropped", 32'(obs_wr), 32'd0);
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, acc);
    check("rst_ready_after", 32'(obs_rdy), 32'd1);
    check("rst_word_kept", dmem[16], old);

    have = 0; rs = 0; rf = 0; ra = 0; rd = 0;
    for (int unsigned it = 0; it < 600; it++) begin
      if (!have && ($urandom_range(0, 3) != 0)) begin
        have = 1;
        rs = $urandom_range(0, 1);
        rf = rs ? st_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
        ra = $urandom;
        if ($urandom_range(0, 1) != 0) ra = ra & ~((32'd1 << rf[1:0]) - 1);
        rd = $urandom;
      end
      if ($urandom_range(0, 60) == 0) begin
        step(1, have, rs, rf, ra, rd, acc);
      end else begin
        step(0, have, rs, rf, ra, rd, acc);
        if (acc) have = 0;
      end
    end
    idle(2);

    for (int unsigned w = 0; w < 1024; w++)
      if (dmem[w] !== ref_word(32'(w) << 2)) check("final_mem", dmem[w], ref_word(32'(w) << 2));
    check("final_mem_word10", dmem[4], ref_word(32'h10));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
